// File: rtl/fast_fourier_correlation_pkg.sv
// Shared types for the correlation receive path: complex sample layout,
// receiver FSM states and the frame-length width.
package fast_fourier_correlation_pkg;

  localparam int LEN_W = 14;

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } cplx16_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} rx_state_t;

  // Square of a signed 16-bit component; -32768^2 = 2^30 still fits.
  function automatic logic [31:0] sq16(input logic signed [15:0] v);
    logic signed [31:0] p;
    p = v * v;
    return p;
  endfunction

endpackage

// File: rtl/corr_peak_receiver_mag.sv
// Two-stage |x|^2 pipeline: stage 1 squares re and im, stage 2 sums them.
// The sample index and valid flag travel alongside the data.
module corr_mag_sq
  import fast_fourier_correlation_pkg::*;
(
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  input  cplx16_t          in_data,
  input  logic [LEN_W-1:0] in_index,
  output logic             out_valid,
  output logic [31:0]      out_mag,
  output logic [LEN_W-1:0] out_index
);

  logic             s1_valid;
  logic [31:0]      re_sq;
  logic [31:0]      im_sq;
  logic [LEN_W-1:0] s1_index;

  // Stage 1: component squares
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid <= 1'b0;
      re_sq    <= 32'd0;
      im_sq    <= 32'd0;
      s1_index <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        re_sq    <= sq16(in_data.re);
        im_sq    <= sq16(in_data.im);
        s1_index <= in_index;
      end
    end
  end

  // Stage 2: sum is at most 2^31, so 32 bits never wrap
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_mag   <= 32'd0;
      out_index <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mag   <= re_sq + im_sq;
        out_index <= s1_index;
      end
    end
  end

endmodule

// File: rtl/corr_peak_receiver.sv
// AXI-Stream sink for correlator output: accepts N1+N2-1 samples per start,
// tracks the peak |x|^2 and its first index, then pulses done.
module corr_peak_receiver
  import fast_fourier_correlation_pkg::*;
#(
  parameter int TIMEOUT = 1024
)
(
  input  logic             aclk,
  input  logic             areset,
  input  logic [12:0]      N1,
  input  logic [12:0]      N2,
  input  logic             start,
  output logic             idle,
  output logic             done,
  output logic             len_error,
  output logic             timeout,
  output logic [31:0]      peak_value,
  output logic [LEN_W-1:0] peak_index,
  output logic [LEN_W-1:0] rx_count,
  input  logic [31:0]      corr_tdata,
  input  logic             corr_tvalid,
  output logic             corr_tready
);

  localparam int STALL_W = $clog2(TIMEOUT + 2);
  localparam bit TO_EN   = (TIMEOUT > 32'sd0);

  rx_state_t        state, state_d;
  logic [LEN_W-1:0] len, len_d, rx_count_d, peak_index_d;
  logic [31:0]      peak_value_d;
  logic [STALL_W-1:0] stall, stall_d;
  logic [1:0]       flush_cnt, flush_cnt_d;
  logic             len_error_d, timeout_d, tready_d;
  logic             beat;
  logic             mag_valid;
  logic [31:0]      mag;
  logic [LEN_W-1:0] mag_index;

  assign beat = corr_tvalid & corr_tready;

  corr_mag_sq u_mag (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (beat),
    .in_data   (cplx16_t'(corr_tdata)),
    .in_index  (rx_count),
    .out_valid (mag_valid),
    .out_mag   (mag),
    .out_index (mag_index)
  );

  // FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, counters, flags and peak tracking
  always_comb begin
    state_d      = state;
    len_d        = len;
    rx_count_d   = rx_count;
    stall_d      = stall;
    flush_cnt_d  = flush_cnt;
    len_error_d  = len_error;
    timeout_d    = timeout;
    peak_value_d = peak_value;
    peak_index_d = peak_index;

    // Strict compare keeps the earliest index on ties
    if (mag_valid && (mag > peak_value)) begin
      peak_value_d = mag;
      peak_index_d = mag_index;
    end else begin
      peak_value_d = peak_value;
    end

    case (state)
      IDLE: begin
        if (start) begin
          rx_count_d   = '0;
          stall_d      = '0;
          flush_cnt_d  = 2'd0;
          timeout_d    = 1'b0;
          peak_value_d = 32'd0;
          peak_index_d = '0;
          if ((N1 != 13'd0) && (N2 != 13'd0)) begin
            len_d       = {1'b0, N1} + {1'b0, N2} - 14'd1;
            len_error_d = 1'b0;
            state_d     = RUN;
          end else begin
            len_error_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (beat) begin
          rx_count_d = rx_count + 14'd1;
          stall_d    = '0;
          if (rx_count_d == len) state_d = FLUSH;
          else                   state_d = RUN;
        end else if (TO_EN && (stall == STALL_W'(TIMEOUT))) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          stall_d = stall + STALL_W'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt == 2'd1) state_d = DONE;
        else                   flush_cnt_d = flush_cnt + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tready_d = (state_d == RUN) && (rx_count_d < len_d);
  end

  // Datapath and registered outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      len         <= '0;
      rx_count    <= '0;
      stall       <= '0;
      flush_cnt   <= 2'd0;
      len_error   <= 1'b0;
      timeout     <= 1'b0;
      peak_value  <= 32'd0;
      peak_index  <= '0;
      corr_tready <= 1'b0;
      idle        <= 1'b1;
      done        <= 1'b0;
    end else begin
      len         <= len_d;
      rx_count    <= rx_count_d;
      stall       <= stall_d;
      flush_cnt   <= flush_cnt_d;
      len_error   <= len_error_d;
      timeout     <= timeout_d;
      peak_value  <= peak_value_d;
      peak_index  <= peak_index_d;
      corr_tready <= tready_d;
      idle        <= (state_d == IDLE);
      done        <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_corr_peak_receiver.sv
// Directed vector bench for corr_peak_receiver: default-TIMEOUT instance plus
// a TIMEOUT=16 instance for the stall-abort frame.
module tb_corr_peak_receiver;

  typedef struct {
    bit          sel;
    logic [12:0] n1, n2;
    int          first, nsamp, mode;
    bit          extra, mid_start;
    logic [31:0] exp_peak;
    logic [13:0] exp_idx, exp_cnt;
    logic        exp_lerr, exp_to;
    int          lat_min, lat_max;
    logic        exp_tr;
  } vec_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [12:0] N1, N2;
  logic        start, start_a, start_b, sel;
  logic [31:0] corr_tdata;
  logic        corr_tvalid;

  logic        idle_a, done_a, lerr_a, to_a, tr_a;
  logic [31:0] pk_a;
  logic [13:0] pi_a, rc_a;
  logic        idle_b, done_b, lerr_b, to_b, tr_b;
  logic [31:0] pk_b;
  logic [13:0] pi_b, rc_b;

  logic        o_idle, o_done, o_lerr, o_to, o_tr;
  logic [31:0] o_pk;
  logic [13:0] o_pi, o_rc;

  int checks = 0;
  int failures = 0;
  logic [31:0] pool[$];
  vec_t vecs[9];

  always #5 aclk = ~aclk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign o_idle = sel ? idle_b : idle_a;
  assign o_done = sel ? done_b : done_a;
  assign o_lerr = sel ? lerr_b : lerr_a;
  assign o_to   = sel ? to_b   : to_a;
  assign o_tr   = sel ? tr_b   : tr_a;
  assign o_pk   = sel ? pk_b   : pk_a;
  assign o_pi   = sel ? pi_b   : pi_a;
  assign o_rc   = sel ? rc_b   : rc_a;

  corr_peak_receiver dut_a (
    .aclk(aclk), .areset(areset), .N1(N1), .N2(N2), .start(start_a),
    .idle(idle_a), .done(done_a), .len_error(lerr_a), .timeout(to_a),
    .peak_value(pk_a), .peak_index(pi_a), .rx_count(rc_a),
    .corr_tdata(corr_tdata), .corr_tvalid(corr_tvalid), .corr_tready(tr_a)
  );

  corr_peak_receiver #(.TIMEOUT(16)) dut_b (
    .aclk(aclk), .areset(areset), .N1(N1), .N2(N2), .start(start_b),
    .idle(idle_b), .done(done_b), .len_error(lerr_b), .timeout(to_b),
    .peak_value(pk_b), .peak_index(pi_b), .rx_count(rc_b),
    .corr_tdata(corr_tdata), .corr_tvalid(corr_tvalid), .corr_tready(tr_b)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic vec_t mkv(bit s, logic [12:0] n1, logic [12:0] n2, int first, int nsamp,
                               int mode, bit extra, bit mid, logic [31:0] pk, logic [13:0] idx,
                               logic [13:0] cnt, logic lerr, logic to, int lmin, int lmax, logic tr);
    vec_t v;
    v.sel = s; v.n1 = n1; v.n2 = n2; v.first = first; v.nsamp = nsamp; v.mode = mode;
    v.extra = extra; v.mid_start = mid; v.exp_peak = pk; v.exp_idx = idx; v.exp_cnt = cnt;
    v.exp_lerr = lerr; v.exp_to = to; v.lat_min = lmin; v.lat_max = lmax; v.exp_tr = tr;
    return v;
  endfunction

  // One frame: start, feed samples, time done relative to the last beat (or start)
  task automatic run_vec(input int id, input vec_t v);
    int p, k, gapcnt, last_ref, done_p;
    bit tog, beat_now, tr_seen;
    logic done_again, idle_after;
    p = 0; k = 0; gapcnt = 0; last_ref = 0; done_p = -1;
    tog = 1'b1; tr_seen = 1'b0; done_again = 1'b1; idle_after = 1'b0;
    sel = v.sel; N1 = v.n1; N2 = v.n2; start = 1'b1; corr_tvalid = 1'b0;
    tick();
    start = 1'b0;
    p = 1;
    while (p < 3000) begin
      if (done_p >= 0) begin
        done_again = o_done;
        idle_after = o_idle;
        break;
      end
      if (o_done) done_p = p;
      tr_seen |= o_tr;
      start = 1'b0;
      N1 = v.n1;
      if (k < v.nsamp) begin
        if (v.mode == 1 && k == 3 && gapcnt < 20) begin
          corr_tvalid = 1'b0;
          if (v.mid_start && gapcnt == 5) begin
            start = 1'b1;
            N1 = 13'd0;
          end
          gapcnt++;
        end else if (v.mode == 1) begin
          corr_tvalid = tog;
          tog = ~tog;
        end else begin
          corr_tvalid = 1'b1;
        end
        corr_tdata = pool[v.first + k];
      end else begin
        corr_tvalid = v.extra;
        corr_tdata  = 32'h7FFF_7FFF;
      end
      beat_now = corr_tvalid & o_tr;
      tick();
      if (beat_now) begin
        k++;
        last_ref = p;
      end
      p++;
    end
    corr_tvalid = 1'b0;
    start = 1'b0;
    chk($sformatf("v%0d peak_value", id), o_pk, v.exp_peak);
    chk($sformatf("v%0d peak_index", id), {18'd0, o_pi}, {18'd0, v.exp_idx});
    chk($sformatf("v%0d rx_count", id), {18'd0, o_rc}, {18'd0, v.exp_cnt});
    chk($sformatf("v%0d len_error", id), {31'd0, o_lerr}, {31'd0, v.exp_lerr});
    chk($sformatf("v%0d timeout", id), {31'd0, o_to}, {31'd0, v.exp_to});
    chk_range($sformatf("v%0d done_latency", id), (done_p < 0) ? -1 : done_p - last_ref,
              v.lat_min, v.lat_max);
    chk($sformatf("v%0d done_one_cycle", id), {31'd0, done_again}, 32'd0);
    chk($sformatf("v%0d idle_after", id), {31'd0, idle_after}, 32'd1);
    chk($sformatf("v%0d tready_seen", id), {31'd0, tr_seen}, {31'd0, v.exp_tr});
  endtask

  initial begin
    pool = '{32'h0000_0001, 32'h0002_0000, 32'h0004_0003, 32'h0000_FFFD, 32'hFFFB_0000, 32'h0000_0000,
             32'h8000_8000,
             32'h0000_0002, 32'h0003_0000, 32'h0000_000A, 32'h0000_0004, 32'h0000_FFF6,
             32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
             32'h0000_0001, 32'h7FFF_7FFF};
    //          sel n1     n2     first n  mode ext mid peak          idx    cnt    lerr  to    lat     tr
    vecs[0] = mkv(0, 13'd4, 13'd3, 0,  6, 0, 1, 0, 32'd25,        14'd0+14'd2, 14'd6, 1'b0, 1'b0, 3, 3, 1'b1);
    vecs[1] = mkv(0, 13'd4, 13'd3, 0,  6, 1, 0, 1, 32'd25,        14'd2, 14'd6, 1'b0, 1'b0, 3, 3, 1'b1);
    vecs[2] = mkv(0, 13'd1, 13'd1, 6,  1, 0, 0, 0, 32'h8000_0000, 14'd0, 14'd1, 1'b0, 1'b0, 3, 3, 1'b1);
    vecs[3] = mkv(0, 13'd0, 13'd5, 0,  0, 0, 1, 0, 32'd0,         14'd0, 14'd0, 1'b1, 1'b0, 1, 1, 1'b0);
    vecs[4] = mkv(1, 13'd6, 13'd5, 7,  5, 0, 0, 0, 32'd100,       14'd2, 14'd5, 1'b0, 1'b1, 16, 20, 1'b1);
    vecs[5] = mkv(0, 13'd2, 13'd2, 12, 3, 0, 0, 0, 32'd0,         14'd0, 14'd3, 1'b0, 1'b0, 3, 3, 1'b1);
    vecs[6] = mkv(0, 13'd2, 13'd1, 15, 2, 0, 0, 0, 32'h7FFE_0002, 14'd1, 14'd2, 1'b0, 1'b0, 3, 3, 1'b1);
    vecs[7] = mkv(0, 13'd3, 13'd0, 0,  0, 0, 0, 0, 32'd0,         14'd0, 14'd0, 1'b1, 1'b0, 1, 1, 1'b0);
    vecs[8] = mkv(0, 13'd2, 13'd1, 0,  2, 0, 0, 0, 32'd4,         14'd1, 14'd2, 1'b0, 1'b0, 3, 3, 1'b1);

    areset = 1'b1; start = 1'b0; sel = 1'b0; N1 = 13'd0; N2 = 13'd0;
    corr_tvalid = 1'b0; corr_tdata = 32'd0;
    repeat (3) tick();
    chk("reset idle", {31'd0, idle_a}, 32'd1);
    chk("reset tready", {31'd0, tr_a}, 32'd0);
    chk("reset done", {31'd0, done_a}, 32'd0);
    chk("reset flags", {30'd0, lerr_a, to_a}, 32'd0);
    chk("reset peak", pk_a, 32'd0);
    chk("reset index_count", {4'd0, pi_a, rc_a}, 32'd0);
    areset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a frame, then an independent short frame
    sel = 1'b0; N1 = 13'd4; N2 = 13'd3; start = 1'b1;
    tick();
    start = 1'b0;
    corr_tvalid = 1'b1; corr_tdata = 32'h0000_7000;
    repeat (3) tick();
    chk("midreset pre rx_count", {18'd0, rc_a}, 32'd3);
    areset = 1'b1;
    #2;
    chk("midreset idle", {31'd0, idle_a}, 32'd1);
    chk("midreset tready", {31'd0, tr_a}, 32'd0);
    chk("midreset rx_count", {18'd0, rc_a}, 32'd0);
    chk("midreset peak", pk_a, 32'd0);
    chk("midreset done_flags", {29'd0, done_a, lerr_a, to_a}, 32'd0);
    corr_tvalid = 1'b0;
    tick();
    areset = 1'b0;
    tick();
    run_vec(8, vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
